net_sched: RTL and testbench

NET_SCHED -- requirements
Module: net_sched

---
 rtl/net_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/net_sched.sv | 137 +++++++++++++
 tb/tb_net_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_pkg.sv
// Shared definitions for the net scheduler: FSM encoding and fixed timing constants.
package net_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    BLANK   = 3'd2,
    RUN     = 3'd3,
    CAPTURE = 3'd4
  } state_e;

  localparam int BLANK_CYC = 2;
  localparam int S_DEFAULT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester closest after last_grant wins.
module rr_arbiter #(
  parameter  int R  = 4,
  localparam int RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [RW-1:0] last_grant,
  output logic          grant_valid,
  output logic [RW-1:0] grant_idx
);

  int unsigned idx;

  // Walk from farthest to nearest so the nearest requester after last_grant is the final winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = R; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % R;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
  end

endmodule

// File: rtl/net_sched.sv
// Sequencer that time-shares one external net between R requesters.
// state   | meaning
// IDLE    | arbitrate pending requests
// LAUNCH  | net_x latched, net_start pulsed
// BLANK   | ignore stale done from the previous run
// RUN     | wait for done or timeout
// CAPTURE | latch net_y, ack next cycle
module net_sched
  import net_pkg::*;
#(
  parameter  int R   = 4,
  parameter  int I   = 784,
  parameter  int O   = 10,
  parameter  int S   = S_DEFAULT,
  parameter  int TMO = 2**20,
  localparam int RW  = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req,
  input  logic [R*I*S-1:0] x_in,
  output logic [R-1:0]     ack,
  output logic [R-1:0]     err,
  output logic [O*S-1:0]   y_out,
  output logic [I*S-1:0]   net_x,
  output logic             net_start,
  input  logic [O*S-1:0]   net_y,
  input  logic             net_done,
  output logic             busy,
  output logic [RW-1:0]    owner
);

  localparam int TW = $clog2(TMO + 1);
  localparam int BW = $clog2(BLANK_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [RW-1:0] LAST_RST = RW'(R - 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    owner_q, owner_d;
  logic [RW-1:0]    last_q, last_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [I*S-1:0]   net_x_q, net_x_d;
  logic [O*S-1:0]   y_q, y_d;
  logic [R-1:0]     ack_q, ack_d;
  logic [R-1:0]     err_q, err_d;
  logic             grant_valid;
  logic [RW-1:0]    grant_idx;

  rr_arbiter #(.R(R)) u_arb (
    .req         (req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    blank_d = blank_q;
    tmo_d   = tmo_q;
    net_x_d = net_x_q;
    y_d     = y_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        // Latch the vector on the grant edge so it is already valid alongside net_start.
        if (grant_valid) begin
          owner_d = grant_idx;
          net_x_d = x_in[int'(grant_idx)*I*S +: I*S];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        blank_d = BW'(BLANK_CYC - 1);
        state_d = BLANK;
      end
      BLANK: begin
        if (blank_q == '0) state_d = RUN;
        else               blank_d = blank_q - BW'(1);
      end
      RUN: begin
        if (tmo_q != TMO_LAST) tmo_d = tmo_q + TW'(1);
        if (net_done) begin
          state_d = CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          err_d[owner_q] = 1'b1;
          last_d         = owner_q;
          state_d        = IDLE;
        end
      end
      CAPTURE: begin
        y_d            = net_y;
        ack_d[owner_q] = 1'b1;
        last_d         = owner_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      blank_q <= '0;
      tmo_q   <= '0;
      net_x_q <= '0;
      y_q     <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      blank_q <= blank_d;
      tmo_q   <= tmo_d;
      net_x_q <= net_x_d;
      y_q     <= y_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign y_out     = y_q;
  assign net_x     = net_x_q;
  assign net_start = (state_q == LAUNCH);
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_net_sched.sv
// Directed + randomized bench for net_sched with a behavioural net stub and round-robin model.
module tb_net_sched;

  localparam int R   = 4;
  localparam int I   = 3;
  localparam int O   = 2;
  localparam int S   = 32;
  localparam int TMO = 16;
  localparam int RW  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [R-1:0]     req = '0;
  logic [R*I*S-1:0] x_in;
  logic [R-1:0]     ack, err;
  logic [O*S-1:0]   y_out, net_y;
  logic [I*S-1:0]   net_x;
  logic             net_start, net_done, busy;
  logic [RW-1:0]    owner;

  int tests = 0;
  int fails = 0;

  logic [I*S-1:0] xs [R];
  logic [O*S-1:0] result = '0;
  logic [O*S-1:0] exp_y  = '0;
  int last_g = R - 1;

  // Net stub: done rises 'delay' edges after start, optionally lingers 'lag' edges after a new start.
  int since    = 0;
  bit launched = 1'b0;
  int delay    = 10;
  int lag      = 0;
  bit hang     = 1'b0;
  bit pre_done = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    x_in = '0;
    for (int r = 0; r < R; r++) x_in[r*I*S +: I*S] = xs[r];
  end

  always @(posedge clk) begin
    if (net_start) begin
      since    <= 1;
      launched <= 1'b1;
    end else if (since < 1000000) begin
      since <= since + 1;
    end
  end

  assign net_done = launched ? ((since <= lag) || (!hang && since >= delay)) : pre_done;
  assign net_y    = (launched && since >= delay) ? result : ~result;

  net_sched #(.R(R), .I(I), .O(O), .S(S), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .x_in      (x_in),
    .ack       (ack),
    .err       (err),
    .y_out     (y_out),
    .net_x     (net_x),
    .net_start (net_start),
    .net_y     (net_y),
    .net_done  (net_done),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rr_next(input logic [R-1:0] mask, input int last);
    for (int k = 1; k <= R; k++) if (mask[(last + k) % R]) return (last + k) % R;
    return -1;
  endfunction

  task automatic rand_x(input int r);
    for (int i = 0; i < I; i++) xs[r][i*S +: S] = $urandom;
  endtask

  task automatic rand_result();
    for (int i = 0; i < O; i++) result[i*S +: S] = $urandom;
  endtask

  // Waits for the grant, then follows one run to its ack/err and checks timing and data.
  task automatic serve(input int exp_o, input int dly, input bit to, input bit drop,
                       output int wait_n);
    logic [I*S-1:0] exp_x;
    logic [R-1:0]   exp_ev;
    int             n;
    int             exp_n;
    bit             ok;
    delay  = dly;
    hang   = to;
    wait_n = 0;
    while (net_start !== 1'b1 && wait_n < 40) begin
      tick();
      wait_n++;
    end
    chk("start_seen", net_start, 1);
    if (net_start !== 1'b1) return;
    exp_x = xs[exp_o];
    chk("owner", owner, exp_o);
    chk("net_x", net_x, exp_x);
    chk("pulse_clear", ack | err, 0);
    rand_x(exp_o);
    if (drop) req[exp_o] = 1'b0;
    ok = 1'b1;
    n  = 0;
    do begin
      tick();
      n++;
      if ((ack | err) === '0) begin
        if (net_start !== 1'b0 || busy !== 1'b1 || owner !== exp_o || net_x !== exp_x) ok = 1'b0;
      end
    end while ((ack | err) === '0 && n < 60);
    exp_n  = to ? 3 + TMO : ((dly > 3 ? dly : 3) + 2);
    exp_ev = '0;
    exp_ev[exp_o] = 1'b1;
    if (!to) exp_y = result;
    chk("run_stable", ok, 1);
    chk("event_cycle", n, exp_n);
    chk(to ? "err_bit" : "ack_bit", to ? err : ack, exp_ev);
    chk(to ? "no_ack" : "no_err", to ? ack : err, 0);
    chk("y_out", y_out, exp_y);
    chk("busy_idle", busy, 0);
    last_g = exp_o;
  endtask

  initial begin
    int wn;
    int g;
    bit quiet;
    logic [R-1:0] pending;

    for (int r = 0; r < R; r++) rand_x(r);
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_start", net_start, 0);
    chk("rst_y", y_out, 0);
    chk("rst_netx", net_x, 0);

    // Single requester, fixed result pattern.
    for (int i = 0; i < O; i++) result[i*S +: S] = 32'h3F80_0000;
    req = 4'b0001;
    serve(0, 10, 1'b0, 1'b0, wn);
    req = '0;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (busy !== 1'b0 || (ack | err) !== '0) quiet = 1'b0;
    end
    chk("single_no_regrant", quiet, 1);

    // Done arrives while still blanking.
    rand_result();
    req = 4'b0010;
    serve(rr_next(4'b0010, last_g), 2, 1'b0, 1'b0, wn);
    req = '0;
    tick();

    // Stale done lingers through BLANK.
    lag = 2;
    rand_result();
    req = 4'b0100;
    serve(rr_next(4'b0100, last_g), 8, 1'b0, 1'b0, wn);
    req = '0;
    lag = 0;
    tick();

    // Full contention from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_y  = '0;
    last_g = R - 1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      g = rr_next(req, last_g);
      chk("rr_order", g, k % R);
      rand_result();
      serve(g, $urandom_range(3, 12), 1'b0, 1'b0, wn);
      if (k > 0) chk("idle_gap", wn, 1);
    end

    // Timeout, then the next requester is served.
    serve(rr_next(req, last_g), 5, 1'b1, 1'b0, wn);
    chk("idle_gap_to", wn, 1);
    rand_result();
    serve(rr_next(req, last_g), 6, 1'b0, 1'b0, wn);
    chk("idle_gap_after_to", wn, 1);
    req = '0;
    tick();

    // Reset during RUN.
    delay = 40;
    hang  = 1'b0;
    req   = 4'b0010;
    wn = 0;
    while (net_start !== 1'b1 && wn < 40) begin
      tick();
      wn++;
    end
    chk("rmr_start", net_start, 1);
    for (int c = 0; c < 5; c++) tick();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_y  = '0;
    last_g = R - 1;
    chk("rmr_busy", busy, 0);
    chk("rmr_owner", owner, 0);
    chk("rmr_pulses", ack | err, 0);
    chk("rmr_y", y_out, 0);
    quiet = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (busy !== 1'b0 || (ack | err) !== '0 || net_start !== 1'b0) quiet = 1'b0;
    end
    chk("rmr_quiet", quiet, 1);
    rand_result();
    req = 4'b0100;
    serve(rr_next(req, last_g), $urandom_range(3, 12), 1'b0, 1'b0, wn);
    req = '0;
    tick();

    // Random request sets; some requesters drop req mid-run.
    for (int round = 0; round < 6; round++) begin
      pending = 4'($urandom_range(1, 15));
      req = pending;
      while (pending != '0) begin
        g = rr_next(pending, last_g);
        rand_result();
        serve(g, $urandom_range(2, 14), 1'b0, 1'($urandom_range(0, 1)), wn);
        pending[g] = 1'b0;
        req = pending;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
